muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 43 ++++
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// muldiv_unit_if
//
// Purpose: groups the EX-stage <-> multiply/divide unit signals.
//
// Handshake: EX raises start with funct3/op_a/op_b valid in the same cycle.
// The unit accepts the operation only in its idle state when flush is low.
// The acceptance is visible through stall, which stays high from the accept
// cycle until the final calculation cycle. done is a one-cycle pulse marking
// the cycle in which result holds the new value. There is no ready signal.
// EX keeps its pipeline frozen while stall is high. It must not expect a
// start that coincides with done to be taken.
//
// Signals:
//   flush  - EX -> unit : abort any in-flight operation
//   start  - EX -> unit : M-extension op present, operands valid
//   funct3 - EX -> unit : operation select
//   op_a   - EX -> unit : rs1 operand
//   op_b   - EX -> unit : rs2 operand
//   stall  - unit -> EX : hold IF/ID/EX registers (combinational)
//   done   - unit -> EX : one-cycle result-valid pulse
//   result - unit -> EX : registered result, held until the next done
// ----------------------------------------------------------------------------
interface muldiv_unit_if;
    logic        flush;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        done;
    logic [31:0] result;

    modport master (
        output flush, start, funct3, op_a, op_b,
        input  stall, done, result
    );

    modport slave (
        input  flush, start, funct3, op_a, op_b,
        output stall, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//
// Purpose: iterative RV32M multiply/divide unit. The multiplier is radix-2
// shift-add and the divider is radix-2 restoring. Each needs 32 steps, one
// per cycle. Both work on operand magnitudes and apply the sign at the end.
// Divide-by-zero and signed overflow finish in a single cycle.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   bus       - muldiv_unit_if.slave (flush/start/funct3/op_a/op_b in,
//               stall/done/result out)
//   fsm_state - current FSM state (0 idle, 1 calc, 2 done) for observation
// ----------------------------------------------------------------------------
module muldiv_unit (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus,
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [5:0]  count;
    // Multiply: {partial product high, multiplier / product low}.
    // Divide:   {partial remainder, dividend / quotient}.
    logic [63:0] work;
    logic [31:0] operand_b;   // multiplicand or divisor magnitude
    logic [2:0]  op_sel;
    logic        neg_main;    // negate product or quotient at the end
    logic        neg_rem;     // negate remainder at the end
    logic [31:0] result_q;

    // ------------------------------------------------------------------
    // Issue-side decode
    // ------------------------------------------------------------------
    logic        accept;
    logic        is_div_in;
    logic        signed_a_in;
    logic        signed_b_in;
    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;
    logic        div_zero;
    logic        div_ovf;
    logic        fast_path;
    logic [31:0] fast_result;

    always_comb begin
        accept      = (state == S_IDLE) & bus.start & ~bus.flush;
        is_div_in   = bus.funct3[2];
        signed_a_in = 1'b0;
        signed_b_in = 1'b0;
        case (bus.funct3)
            3'b001:         begin signed_a_in = 1'b1; signed_b_in = 1'b1; end // MULH
            3'b010:         signed_a_in = 1'b1;                               // MULHSU
            3'b100, 3'b110: begin signed_a_in = 1'b1; signed_b_in = 1'b1; end // DIV, REM
            default:        ;
        endcase
        a_neg_in = signed_a_in & bus.op_a[31];
        b_neg_in = signed_b_in & bus.op_b[31];
        // The magnitude of 0x80000000 is still 0x80000000 when read as unsigned.
        mag_a_in = a_neg_in ? (~bus.op_a + 32'd1) : bus.op_a;
        mag_b_in = b_neg_in ? (~bus.op_b + 32'd1) : bus.op_b;

        div_zero = is_div_in & (bus.op_b == 32'd0);
        div_ovf  = is_div_in & ~bus.funct3[0] &
                   (bus.op_a == 32'h8000_0000) & (bus.op_b == 32'hFFFF_FFFF);
        fast_path = div_zero | div_ovf;

        if (div_zero)
            fast_result = bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF;
        else
            fast_result = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // ------------------------------------------------------------------
    // One radix-2 step
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [33:0] div_diff;
    logic        div_ge;
    logic [63:0] work_step;

    always_comb begin
        mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, operand_b} : 33'd0);
        // The shifted partial remainder can reach 33 bits, so compare work[63:31].
        div_diff = {1'b0, work[63:31]} - {2'b00, operand_b};
        div_ge   = ~div_diff[33];
        if (op_sel[2])
            work_step = {(div_ge ? div_diff[31:0] : work[62:31]), work[30:0], div_ge};
        else
            work_step = {mul_sum, work[31:1]};
    end

    // ------------------------------------------------------------------
    // Final sign correction and result select from the last step
    // ------------------------------------------------------------------
    logic [63:0] prod_signed;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] calc_result;

    always_comb begin
        prod_signed = neg_main ? (~work_step + 64'd1) : work_step;
        quot        = neg_main ? (~work_step[31:0] + 32'd1) : work_step[31:0];
        rem         = neg_rem  ? (~work_step[63:32] + 32'd1) : work_step[63:32];
        if (op_sel[2])
            calc_result = op_sel[1] ? rem : quot;
        else
            calc_result = (op_sel[1:0] == 2'b00) ? prod_signed[31:0] : prod_signed[63:32];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = fast_path ? S_DONE : S_CALC;
            S_CALC:  if (count == 6'd31) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // Flush wins over start and over completion.
        if (bus.flush)
            state_next = S_IDLE;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 6'd0;
            work      <= 64'd0;
            operand_b <= 32'd0;
            op_sel    <= 3'd0;
            neg_main  <= 1'b0;
            neg_rem   <= 1'b0;
            result_q  <= 32'd0;
        end else if (bus.flush) begin
            count <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_sel    <= bus.funct3;
                        count     <= 6'd0;
                        work      <= {32'd0, mag_a_in};
                        operand_b <= mag_b_in;
                        neg_main  <= a_neg_in ^ b_neg_in;
                        neg_rem   <= a_neg_in;
                        if (fast_path)
                            result_q <= fast_result;
                    end
                end
                S_CALC: begin
                    work  <= work_step;
                    count <= count + 6'd1;
                    if (count == 6'd31)
                        result_q <= calc_result;
                end
                default: count <= 6'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall  = ~rst & (accept | (state == S_CALC));
    assign bus.done   = ~rst & (state == S_DONE) & ~bus.flush;
    assign bus.result = result_q;
    assign fsm_state  = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Purpose: self-checking bench for muldiv_unit. It applies a table of directed
// vectors and checks result value and done latency for each. It also runs
// hand-written sequences for start held during CALC, flush mid-operation,
// flush in the done cycle, flush together with start, and reset mid-operation.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic       clk;
    logic       rst;
    logic [1:0] fsm_state;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle T, then wait for done.
    // hold_start keeps start high with junk operands until the done cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res,
                          input string name, input bit hold_start);
        int cyc;
        bit stall_ok;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        #1;
        check({name, " stall_at_T"}, 32'(bus.stall), 32'd1);
        cyc      = 0;
        stall_ok = 1'b1;
        tick();
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (hold_start) begin
                bus.funct3 = 3'($urandom_range(0, 7));
                bus.op_a   = $urandom;
                bus.op_b   = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            tick();
            cyc++;
        end
        if (!hold_start) bus.start = 1'b0;
        #1;
        check({name, " done_latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " result"}, bus.result, exp_res);
        check({name, " stall_in_done"}, 32'(bus.stall), 32'd0);
        check({name, " stall_while_busy"}, 32'(stall_ok), 32'd1);
        tick();
        check({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
        if (hold_start) begin
            // A start coincident with done must not be taken.
            check({name, " idle_after_done"}, 32'(fsm_state), 32'd0);
            bus.start = 1'b0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] saved;
        bit          saw_done;

        vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7*-3"});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU max*max"});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "MULH -1*-1"});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU -1*max"});
        vecs.push_back('{3'b000, 32'h1234_5678, 32'd9,         32'hA3D7_0A38, 33, "MUL 0x12345678*9"});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH min*min"});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 33, "MULH min*2"});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "DIV -7/2"});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "REM -7/2"});
        vecs.push_back('{3'b101, 32'd100,        32'd7,         32'd14,        33, "DIVU 100/7"});
        vecs.push_back('{3'b111, 32'd100,        32'd7,         32'd2,         33, "REMU 100/7"});
        vecs.push_back('{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "DIV 7/-2"});
        vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33, "REM 7/-2"});
        vecs.push_back('{3'b110, 32'hFFFF_FFF8, 32'd3,         32'hFFFF_FFFE, 33, "REM -8/3"});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, "DIVU max/1"});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 33, "DIVU max/10"});
        vecs.push_back('{3'b111, 32'hFFFF_FFFF, 32'd10,        32'd5,         33, "REMU max/10"});
        vecs.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "REMU min/max"});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, 33, "DIV min/2"});
        vecs.push_back('{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "DIV 5/0"});
        vecs.push_back('{3'b111, 32'd5,          32'd0,         32'd5,         1,  "REMU 5/0"});
        vecs.push_back('{3'b101, 32'd9,          32'd0,         32'hFFFF_FFFF, 1,  "DIVU 9/0"});
        vecs.push_back('{3'b110, 32'd9,          32'd0,         32'd9,         1,  "REM 9/0"});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "DIV ovf"});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "REM ovf"});

        // ---------------- reset ----------------
        rst        = 1'b1;
        bus.flush  = 1'b0;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        repeat (3) tick();
        check("reset stall_during_rst", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        #1;
        check("reset result", bus.result, 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset stall", 32'(bus.stall), 32'd0);
        check("reset state", 32'(fsm_state), 32'd0);

        // ---------------- table ----------------
        foreach (vecs[i])
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].exp, vecs[i].name, 1'b0);

        // ---------------- start held during CALC and at done ----------------
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, "MUL hold_start", 1'b1);
        run_op(3'b100, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "DIV0 hold_start", 1'b1);

        // ---------------- flush at T+10 ----------------
        run_op(3'b101, 32'd100, 32'd7, 33, 32'd14, "pre-flush DIVU", 1'b0);
        saved = bus.result;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b111; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        tick();                       // T+1
        bus.start = 1'b0;
        repeat (9) tick();            // T+10
        check("flush stall_before", 32'(bus.stall), 32'd1);
        bus.flush = 1'b1;
        tick();                       // T+11
        bus.flush = 1'b0;
        #1;
        check("flush state_T+11", 32'(fsm_state), 32'd0);
        check("flush stall_T+11", 32'(bus.stall), 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("flush no_done", 32'(saw_done), 32'd0);
        check("flush result_kept", bus.result, saved);

        // ---------------- flush in the done cycle ----------------
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b110; bus.op_a = 32'd77; bus.op_b = 32'd0;
        tick();                       // T+1: DONE
        bus.start = 1'b0;
        bus.flush = 1'b1;
        #1;
        check("flush_done done_masked", 32'(bus.done), 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("flush_done state_idle", 32'(fsm_state), 32'd0);
        check("flush_done no_late_done", 32'(bus.done), 32'd0);

        // ---------------- flush together with start ----------------
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd3;
        #1;
        check("flush_start stall", 32'(bus.stall), 32'd0);
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        check("flush_start not_taken", 32'(fsm_state), 32'd0);

        // ---------------- reset at T+5 of a DIVU ----------------
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd500; bus.op_b = 32'd9;
        tick();                       // T+1
        bus.start = 1'b0;
        repeat (4) tick();            // T+5
        rst = 1'b1;
        #1;
        check("rst_mid done", 32'(bus.done), 32'd0);
        check("rst_mid stall", 32'(bus.stall), 32'd0);
        tick();                       // T+6
        rst = 1'b0;
        #1;
        check("rst_mid state_idle", 32'(fsm_state), 32'd0);
        check("rst_mid result_zero", bus.result, 32'd0);
        tick();                       // T+7
        tick();                       // T+8
        run_op(3'b101, 32'd500, 32'd9, 33, 32'd55, "post-rst DIVU 500/9", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
